// File: rtl/axis_hdr_pkg.sv
// ============================================================================
// Module      : axis_hdr_pkg
// Description : Shared header layout constants and channel FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_hdr_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hC0DE;

    localparam int CNT_LSB = 0;
    localparam int CH_W    = 8;
    localparam int MAGIC_W = 16;
    localparam int TS_LSB  = 64;
    localparam int TS_W    = 64;

    typedef enum logic [0:0] {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } hdr_state_e;

    // Channel and magic fields float above the configurable-width counter.
    function automatic int ch_lsb(input int cnt_w);
        return CNT_LSB + cnt_w;
    endfunction

    function automatic int magic_lsb(input int cnt_w);
        return ch_lsb(cnt_w) + CH_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_hdr_chan.sv
// ============================================================================
// Module      : axis_hdr_chan
// Description : One AXI-Stream channel engine: header/payload FSM, packet
//               counter and registered output slot. HDR_TIMESTAMP_EN adds a
//               timestamp input written into the header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_hdr_chan
    import axis_hdr_pkg::*;
#(
    parameter int DW    = 512,
    parameter int CNT_W = 32,
    parameter int CH    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic [DW/8-1:0]   s_tkeep_i,
    input  logic              s_tlast_i,
    output logic [DW-1:0]     m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic [DW/8-1:0]   m_tkeep_o,
    output logic              m_tlast_o,
    output logic [CNT_W-1:0]  pkt_count_o
`ifdef HDR_TIMESTAMP_EN
    ,
    input  logic [TS_W-1:0]   ts_i
`endif
);

    localparam int              c_ch_lsb    = ch_lsb(CNT_W);
    localparam int              c_magic_lsb = magic_lsb(CNT_W);
    localparam logic [CH_W-1:0] c_ch_idx    = CH_W'(CH);

    hdr_state_e         state_q, state_d;
    logic [DW-1:0]      tdata_q, tdata_d;
    logic [DW/8-1:0]    tkeep_q, tkeep_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      w_hdr;
    logic               w_slot_free;

    assign w_slot_free = !tvalid_q || m_tready_i;

    always_comb begin
        w_hdr                           = '0;
        w_hdr[CNT_LSB +: CNT_W]         = cnt_q;
        w_hdr[c_ch_lsb +: CH_W]         = c_ch_idx;
        w_hdr[c_magic_lsb +: MAGIC_W]   = HDR_MAGIC;
`ifdef HDR_TIMESTAMP_EN
        w_hdr[TS_LSB +: TS_W]           = ts_i;
`endif
    end

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        cnt_d      = cnt_q;
        s_tready_o = 1'b0;
        // A consumed beat empties the slot unless something reloads it below.
        tvalid_d   = tvalid_q && !w_slot_free;
        unique case (state_q)
            HDR: begin
                if (s_tvalid_i && w_slot_free) begin
                    tdata_d  = w_hdr;
                    tvalid_d = 1'b1;
                    tkeep_d  = '1;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_tready_o = w_slot_free;
                if (s_tvalid_i && w_slot_free) begin
                    tdata_d  = s_tdata_i;
                    tvalid_d = 1'b1;
                    tkeep_d  = s_tkeep_i;
                    tlast_d  = s_tlast_i;
                    if (s_tlast_i) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HDR;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_tdata_o   = tdata_q;
    assign m_tkeep_o   = tkeep_q;
    assign m_tvalid_o  = tvalid_q;
    assign m_tlast_o   = tlast_q;
    assign pkt_count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/axis_counter_header_inserter.sv
// ============================================================================
// Module      : axis_counter_header_inserter
// Description : NCH independent AXI-Stream channels, each prefixing every
//               packet with a counter header. HDR_TIMESTAMP_EN adds a shared
//               64-bit cycle timestamp to every header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_counter_header_inserter
    import axis_hdr_pkg::*;
#(
    parameter int DW    = 512,
    parameter int NCH   = 2,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*DW-1:0]      s_tdata,
    input  logic [NCH-1:0]         s_tvalid,
    output logic [NCH-1:0]         s_tready,
    input  logic [NCH*DW/8-1:0]    s_tkeep,
    input  logic [NCH-1:0]         s_tlast,
    output logic [NCH*DW-1:0]      m_tdata,
    output logic [NCH-1:0]         m_tvalid,
    input  logic [NCH-1:0]         m_tready,
    output logic [NCH*DW/8-1:0]    m_tkeep,
    output logic [NCH-1:0]         m_tlast,
    output logic [NCH*CNT_W-1:0]   pkt_count
);

    if (DW < 64 || (DW % 8) != 0) begin : g_bad_dw
        $error("DW must be a multiple of 8 and at least 64");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("NCH must be in 1..16");
    end
    if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt
        $error("CNT_W must be in 8..32");
    end

`ifdef HDR_TIMESTAMP_EN
    if (DW < 128) begin : g_bad_dw_ts
        $error("HDR_TIMESTAMP_EN requires DW >= 128");
    end

    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        axis_hdr_chan #(
            .DW    (DW),
            .CNT_W (CNT_W),
            .CH    (c)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .s_tdata_i   (s_tdata[c*DW +: DW]),
            .s_tvalid_i  (s_tvalid[c]),
            .s_tready_o  (s_tready[c]),
            .s_tkeep_i   (s_tkeep[c*DW/8 +: DW/8]),
            .s_tlast_i   (s_tlast[c]),
            .m_tdata_o   (m_tdata[c*DW +: DW]),
            .m_tvalid_o  (m_tvalid[c]),
            .m_tready_i  (m_tready[c]),
            .m_tkeep_o   (m_tkeep[c*DW/8 +: DW/8]),
            .m_tlast_o   (m_tlast[c]),
            .pkt_count_o (pkt_count[c*CNT_W +: CNT_W])
`ifdef HDR_TIMESTAMP_EN
            ,
            .ts_i        (ts_q)
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_counter_header_inserter.sv
// ============================================================================
// Module      : tb_axis_counter_header_inserter
// Description : Self-checking bench: vector table for channel 0 plus stream
//               sequences for back-to-back, backpressure, wrap and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_counter_header_inserter;

    localparam int NCH   = 2;
    localparam int DW    = 128;
    localparam int CNT_W = 8;
    localparam int KW    = DW / 8;

    logic                  clk;
    logic                  reset;
    logic [NCH*DW-1:0]     s_tdata;
    logic [NCH-1:0]        s_tvalid;
    logic [NCH-1:0]        s_tready;
    logic [NCH*KW-1:0]     s_tkeep;
    logic [NCH-1:0]        s_tlast;
    logic [NCH*DW-1:0]     m_tdata;
    logic [NCH-1:0]        m_tvalid;
    logic [NCH-1:0]        m_tready;
    logic [NCH*KW-1:0]     m_tkeep;
    logic [NCH-1:0]        m_tlast;
    logic [NCH*CNT_W-1:0]  pkt_count;

    axis_counter_header_inserter #(.DW(DW), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          hdr;
    } beat_t;

    typedef struct {
        logic          sv;
        logic [31:0]   tag;
        logic [KW-1:0] keep;
        logic          sl;
        logic          mr;
        logic          exp_sr;
        logic          exp_mv;
        logic          exp_hdr;
        logic [7:0]    exp_cnt;
        logic [31:0]   exp_tag;
        logic [KW-1:0] exp_keep;
        logic          exp_ml;
    } vec_t;

    beat_t            src_q [2][$];
    beat_t            exp_q [2][$];
    logic [CNT_W-1:0] nxt_cnt [2];
    int               ch1_beats, ch1_first, ch1_last;

    function automatic logic [DW-1:0] mk(input logic [31:0] tag);
        return {tag, tag, tag, tag};
    endfunction

    function automatic logic [DW-1:0] hdr_word(input logic [7:0] cnt, input int ch);
        return {64'h0, 32'h0, 16'hC0DE, 8'(ch), cnt};
    endfunction

    function automatic logic [DW-1:0] mask_hdr(input logic [DW-1:0] d, input logic is_hdr);
        logic [DW-1:0] r;
        r = d;
`ifdef HDR_TIMESTAMP_EN
        if (is_hdr) r[127:64] = '0;
`else
        if (is_hdr) r = d;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic l);
        s_tvalid[c]          = v;
        s_tdata[c*DW +: DW]  = d;
        s_tkeep[c*KW +: KW]  = k;
        s_tlast[c]           = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = '1;
        cyc();
        cyc();
        reset      = 1'b0;
        nxt_cnt[0] = '0;
        nxt_cnt[1] = '0;
    endtask

    task automatic add_pkt(input int c, input int n, input logic [31:0] tag0);
        beat_t b;
        b = '{data: hdr_word(nxt_cnt[c], c), keep: '1, last: 1'b0, hdr: 1'b1};
        exp_q[c].push_back(b);
        nxt_cnt[c] = nxt_cnt[c] + 1'b1;
        for (int i = 0; i < n; i++) begin
            b.data = mk(tag0 + 32'(i));
            b.keep = (i == n - 1) ? 16'h0fff : 16'hffff;
            b.last = (i == n - 1);
            b.hdr  = 1'b0;
            src_q[c].push_back(b);
            exp_q[c].push_back(b);
        end
    endtask

    task automatic run_streams(input int max_cyc, input bit rnd0);
        logic          stall [2];
        logic [DW-1:0] pd [2];
        logic [KW-1:0] pk [2];
        logic          pl [2];
        logic [DW-1:0] ad;
        beat_t         e;
        int            n;
        n = 0;
        ch1_beats = 0;
        ch1_first = -1;
        ch1_last  = -1;
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) > 0
               && n < max_cyc) begin
            for (int c = 0; c < 2; c++) begin
                if (src_q[c].size() > 0)
                    drive(c, 1'b1, src_q[c][0].data, src_q[c][0].keep, src_q[c][0].last);
                else
                    drive(c, 1'b0, '0, '0, 1'b0);
            end
            m_tready[0] = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready[1] = 1'b1;
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                ad = m_tdata[c*DW +: DW];
                if (stall[c]) begin
                    checks++;
                    if (!m_tvalid[c] || ad !== pd[c] || m_tkeep[c*KW +: KW] !== pk[c] || m_tlast[c] !== pl[c]) begin
                        errors++;
                        $display("FAIL stall_hold_ch%0d actual=%h/%b required=%h/1", c, ad, m_tvalid[c], pd[c]);
                    end
                end
                if (m_tvalid[c] && m_tready[c]) begin
                    if (c == 1) begin
                        ch1_beats++;
                        if (ch1_first < 0) ch1_first = n;
                        ch1_last = n;
                    end
                    if (exp_q[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat_ch%0d actual=%h required=none", c, ad);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk($sformatf("stream_data_ch%0d", c), mask_hdr(ad, e.hdr), e.data);
                        chk($sformatf("stream_keep_ch%0d", c), DW'(m_tkeep[c*KW +: KW]), DW'(e.keep));
                        chk($sformatf("stream_last_ch%0d", c), DW'(m_tlast[c]), DW'(e.last));
                    end
                end
                if (s_tvalid[c] && s_tready[c]) void'(src_q[c].pop_front());
                stall[c] = m_tvalid[c] && !m_tready[c];
                pd[c]    = ad;
                pk[c]    = m_tkeep[c*KW +: KW];
                pl[c]    = m_tlast[c];
            end
            cyc();
            n++;
        end
        chk("stream_drained", DW'(src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()), '0);
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        m_tready = '1;
    endtask

    localparam int NV = 15;
    vec_t vec [NV];

    initial begin
        logic [DW-1:0] exp_d;
`ifdef HDR_TIMESTAMP_EN
        logic [63:0] ts1;
`endif
        //            sv    tag           keep      sl    mr    sr    mv    hdr   cnt   etag          ekeep     ml
        vec[0]  = '{1'b1, 32'h11111111, 16'hffff, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 32'h0,        16'hffff, 1'b0};
        vec[1]  = '{1'b1, 32'h11111111, 16'hffff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h11111111, 16'hffff, 1'b0};
        vec[2]  = '{1'b1, 32'h22222222, 16'hffff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h22222222, 16'hffff, 1'b0};
        vec[3]  = '{1'b1, 32'h33333333, 16'hffff, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h33333333, 16'hffff, 1'b1};
        vec[4]  = '{1'b0, 32'h0,        16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        16'h0000, 1'b0};
        vec[5]  = '{1'b1, 32'h44444444, 16'h00ff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 32'h0,        16'hffff, 1'b0};
        vec[6]  = '{1'b1, 32'h44444444, 16'h00ff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 32'h0,        16'hffff, 1'b0};
        vec[7]  = '{1'b1, 32'h44444444, 16'h00ff, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h44444444, 16'h00ff, 1'b1};
        vec[8]  = '{1'b0, 32'h0,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h44444444, 16'h00ff, 1'b1};
        vec[9]  = '{1'b0, 32'h0,        16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        16'h0000, 1'b0};
        vec[10] = '{1'b1, 32'h55555555, 16'hffff, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 32'h0,        16'hffff, 1'b0};
        vec[11] = '{1'b1, 32'h55555555, 16'hffff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h55555555, 16'hffff, 1'b0};
        vec[12] = '{1'b0, 32'h0,        16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        16'h0000, 1'b0};
        vec[13] = '{1'b1, 32'h66666666, 16'hffff, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'h66666666, 16'hffff, 1'b1};
        vec[14] = '{1'b0, 32'h0,        16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        16'h0000, 1'b0};

        do_reset();
        chk("rst_m_tvalid", DW'(m_tvalid), '0);
        chk("rst_m_tdata0", m_tdata[0 +: DW], '0);
        chk("rst_m_tkeep", DW'(m_tkeep), '0);
        chk("rst_m_tlast", DW'(m_tlast), '0);
        chk("rst_s_tready", DW'(s_tready), '0);
        chk("rst_pkt_count", DW'(pkt_count), '0);

        // Channel 0 cycle-by-cycle table; channel 1 idle.
        for (int i = 0; i < NV; i++) begin
            drive(0, vec[i].sv, mk(vec[i].tag), vec[i].keep, vec[i].sl);
            m_tready[0] = vec[i].mr;
            #1;
            chk($sformatf("vec%0d_s_tready", i), DW'(s_tready[0]), DW'(vec[i].exp_sr));
            cyc();
            chk($sformatf("vec%0d_m_tvalid", i), DW'(m_tvalid[0]), DW'(vec[i].exp_mv));
            if (vec[i].exp_mv) begin
                exp_d = vec[i].exp_hdr ? hdr_word(vec[i].exp_cnt, 0) : mk(vec[i].exp_tag);
                chk($sformatf("vec%0d_m_tdata", i), mask_hdr(m_tdata[0 +: DW], vec[i].exp_hdr), exp_d);
                chk($sformatf("vec%0d_m_tkeep", i), DW'(m_tkeep[0 +: KW]), DW'(vec[i].exp_keep));
                chk($sformatf("vec%0d_m_tlast", i), DW'(m_tlast[0]), DW'(vec[i].exp_ml));
            end
        end
        chk("table_pkt_count0", DW'(pkt_count[0 +: CNT_W]), DW'(3));
        chk("table_pkt_count1", DW'(pkt_count[CNT_W +: CNT_W]), '0);

        // Back-to-back 1, 2, 1 beat packets on channel 1.
        do_reset();
        add_pkt(1, 1, 32'hA0000000);
        add_pkt(1, 2, 32'hB0000000);
        add_pkt(1, 1, 32'hC0000000);
        run_streams(100, 1'b0);
        chk("b2b_pkt_count1", DW'(pkt_count[CNT_W +: CNT_W]), DW'(3));

        // Channel 0 randomly stalled, channel 1 at full rate with 3-beat packets.
        do_reset();
        for (int p = 0; p < 6; p++) add_pkt(0, 1 + (p % 4), 32'h01000000 * (p + 1));
        for (int p = 0; p < 10; p++) add_pkt(1, 3, 32'h10000000 + 32'h100 * p);
        run_streams(500, 1'b1);
        chk("rate_ch1_beats", DW'(ch1_beats), DW'(40));
        chk("rate_ch1_span", DW'(ch1_last - ch1_first + 1), DW'(40));

        // Counter wrap with 8-bit counter.
        do_reset();
        for (int p = 0; p < 257; p++) add_pkt(0, 1, 32'(p));
        run_streams(3000, 1'b0);
        chk("wrap_pkt_count0", DW'(pkt_count[0 +: CNT_W]), DW'(1));

        // Reset while beat 2 of a 4-beat packet is presented.
        do_reset();
        drive(0, 1'b1, mk(32'hE1E1E1E1), '1, 1'b0);
        cyc();
        chk("rmid_hdr", mask_hdr(m_tdata[0 +: DW], 1'b1), hdr_word(8'd0, 0));
        cyc();
        chk("rmid_beat1", m_tdata[0 +: DW], mk(32'hE1E1E1E1));
        drive(0, 1'b1, mk(32'hE2E2E2E2), '1, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rmid_m_tvalid", DW'(m_tvalid[0]), '0);
        chk("rmid_pkt_count", DW'(pkt_count[0 +: CNT_W]), '0);
        drive(0, 1'b1, mk(32'hE3E3E3E3), '1, 1'b0);
        #1;
        chk("rmid_s_tready", DW'(s_tready[0]), '0);
        cyc();
        chk("rmid_new_hdr_valid", DW'(m_tvalid[0]), DW'(1));
        chk("rmid_new_hdr", mask_hdr(m_tdata[0 +: DW], 1'b1), hdr_word(8'd0, 0));
        cyc();
        chk("rmid_beat3", m_tdata[0 +: DW], mk(32'hE3E3E3E3));
        drive(0, 1'b1, mk(32'hE4E4E4E4), '1, 1'b1);
        cyc();
        chk("rmid_beat4", m_tdata[0 +: DW], mk(32'hE4E4E4E4));
        chk("rmid_beat4_last", DW'(m_tlast[0]), DW'(1));
        drive(0, 1'b0, '0, '0, 1'b0);
        cyc();

`ifdef HDR_TIMESTAMP_EN
        // Two headers loaded exactly 10 cycles apart.
        do_reset();
        drive(0, 1'b1, mk(32'h77777777), '1, 1'b1);
        cyc();
        ts1 = m_tdata[127:64];
        cyc();
        drive(0, 1'b0, '0, '0, 1'b0);
        repeat (8) cyc();
        drive(0, 1'b1, mk(32'h88888888), '1, 1'b1);
        cyc();
        chk("ts_delta", DW'(m_tdata[127:64] - ts1), DW'(10));
        cyc();
        drive(0, 1'b0, '0, '0, 1'b0);
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
